// File: rtl/rvb_simple_core.sv
// Bitmanip "simple" execution unit: logic-with-negate, min/max, pack, cmix/cmov
// and the RV64 unsigned-word add/sub ops, with one registered output stage.
module rvb_simple_core #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            din_valid,
    output logic            din_ready,
    input  logic [XLEN-1:0] din_rs1,
    input  logic [XLEN-1:0] din_rs2,
    input  logic [XLEN-1:0] din_rs3,
    input  logic            din_insn3,
    input  logic            din_insn5,
    input  logic            din_insn12,
    input  logic            din_insn13,
    input  logic            din_insn14,
    input  logic            din_insn25,
    input  logic            din_insn26,
    input  logic            din_insn27,
    input  logic            din_insn30,
    output logic            dout_valid,
    input  logic            dout_ready,
    output logic [XLEN-1:0] dout_rd
);

    logic            r_dout_valid;
    logic [XLEN-1:0] r_dout_rd;

    logic [2:0]      w_f3;
    logic            w_insn3;
    logic            w_insn5;
    logic            w_accept;
    logic            w_lt_s;
    logic            w_lt_u;
    logic [31:0]     w_addw;
    logic [31:0]     w_subw;
    logic [XLEN-1:0] w_rs2_zext32;
    logic [XLEN-1:0] w_result;

    assign w_f3     = {din_insn14, din_insn13, din_insn12};
    // On RV32 the W-op encodings do not exist: behave as if insn3=0, insn5=1.
    assign w_insn3  = (XLEN == 64) && din_insn3;
    assign w_insn5  = (XLEN != 64) || din_insn5;

    assign din_ready = !r_dout_valid || dout_ready;
    assign w_accept  = din_valid && din_ready;

    assign w_lt_s       = $signed(din_rs1) < $signed(din_rs2);
    assign w_lt_u       = din_rs1 < din_rs2;
    assign w_addw       = din_rs1[31:0] + din_rs2[31:0];
    assign w_subw       = din_rs1[31:0] - din_rs2[31:0];
    assign w_rs2_zext32 = XLEN'(din_rs2[31:0]);

    always_comb begin
        w_result = '0;
        if (din_insn26) begin
            if (w_f3 == 3'b001)
                w_result = (din_rs1 & din_rs2) | (din_rs3 & ~din_rs2);
            else if (w_f3 == 3'b101)
                w_result = (din_rs2 != '0) ? din_rs1 : din_rs3;
        end else if (!w_insn3) begin
            if (!din_insn27) begin
                if (din_insn30) begin
                    case (w_f3)
                        3'b111:  w_result = din_rs1 & ~din_rs2;
                        3'b110:  w_result = din_rs1 | ~din_rs2;
                        3'b100:  w_result = ~(din_rs1 ^ din_rs2);
                        default: w_result = '0;
                    endcase
                end
            end else if (din_insn25) begin
                case (w_f3)
                    3'b100:  w_result = w_lt_s ? din_rs1 : din_rs2;
                    3'b101:  w_result = w_lt_s ? din_rs2 : din_rs1;
                    3'b110:  w_result = w_lt_u ? din_rs1 : din_rs2;
                    3'b111:  w_result = w_lt_u ? din_rs2 : din_rs1;
                    default: w_result = '0;
                endcase
            end else begin
                case (w_f3)
                    3'b100: begin
                        if (din_insn30)
                            w_result = {din_rs2[XLEN-1:XLEN/2], din_rs1[XLEN-1:XLEN/2]};
                        else
                            w_result = {din_rs2[XLEN/2-1:0], din_rs1[XLEN/2-1:0]};
                    end
                    3'b111:  w_result = {{(XLEN-16){1'b0}}, din_rs2[7:0], din_rs1[7:0]};
                    default: w_result = '0;
                endcase
            end
        end else if (w_f3 == 3'b000) begin
            if (!w_insn5)
                w_result = XLEN'(w_addw);
            else if (din_insn25)
                w_result = din_insn30 ? XLEN'(w_subw) : XLEN'(w_addw);
            else if (din_insn27)
                w_result = din_insn30 ? (din_rs1 - w_rs2_zext32) : (din_rs1 + w_rs2_zext32);
        end
    end

    // Accept wins over drain, so a simultaneous accept/drain keeps dout_valid high.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_dout_valid <= 1'b0;
            r_dout_rd    <= '0;
        end else if (w_accept) begin
            r_dout_valid <= 1'b1;
            r_dout_rd    <= w_result;
        end else if (dout_ready) begin
            r_dout_valid <= 1'b0;
        end
    end

    assign dout_valid = r_dout_valid;
    assign dout_rd    = r_dout_rd;

endmodule

// File: tb/tb_rvb_simple_core.sv
// Scoreboard bench: RV32 and RV64 instances share stimulus; a reference model
// predicts each accepted op and a negedge monitor checks results in order.
module tb_rvb_simple_core;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        din_valid = 1'b0;
    logic        dout_ready = 1'b0;
    logic [63:0] rs1 = '0, rs2 = '0, rs3 = '0;
    logic [8:0]  ctl = '0;   // {i30,i27,i26,i25,f3[2:0],i5,i3}

    logic        din_ready32, dout_valid32;
    logic [31:0] dout_rd32;
    logic        din_ready64, dout_valid64;
    logic [63:0] dout_rd64;

    int n_vec = 0;
    int n_err = 0;
    int rdy_eighths = 8;

    logic [63:0] q32[$];
    logic [63:0] q64[$];
    bit          prev_stall[2];
    logic [63:0] prev_rd[2];

    always #5 clock = ~clock;

    rvb_simple_core #(.XLEN(32)) dut32 (
        .clock(clock), .reset(reset),
        .din_valid(din_valid), .din_ready(din_ready32),
        .din_rs1(rs1[31:0]), .din_rs2(rs2[31:0]), .din_rs3(rs3[31:0]),
        .din_insn3(ctl[0]), .din_insn5(ctl[1]),
        .din_insn12(ctl[2]), .din_insn13(ctl[3]), .din_insn14(ctl[4]),
        .din_insn25(ctl[5]), .din_insn26(ctl[6]), .din_insn27(ctl[7]), .din_insn30(ctl[8]),
        .dout_valid(dout_valid32), .dout_ready(dout_ready), .dout_rd(dout_rd32)
    );

    rvb_simple_core #(.XLEN(64)) dut64 (
        .clock(clock), .reset(reset),
        .din_valid(din_valid), .din_ready(din_ready64),
        .din_rs1(rs1), .din_rs2(rs2), .din_rs3(rs3),
        .din_insn3(ctl[0]), .din_insn5(ctl[1]),
        .din_insn12(ctl[2]), .din_insn13(ctl[3]), .din_insn14(ctl[4]),
        .din_insn25(ctl[5]), .din_insn26(ctl[6]), .din_insn27(ctl[7]), .din_insn30(ctl[8]),
        .dout_valid(dout_valid64), .dout_ready(dout_ready), .dout_rd(dout_rd64)
    );

    function automatic logic [8:0] mk(input logic [2:0] f3, input logic i30, i27, i26, i25, i5, i3);
        return {i30, i27, i26, i25, f3, i5, i3};
    endfunction

    // Reference model: instruction semantics written directly as arithmetic on masked operands.
    function automatic logic [63:0] model(input int xl, input logic [63:0] a_in, b_in, c_in,
                                          input logic [8:0] c);
        logic [63:0] mask, a, b, x, sa, sb, r, lo32;
        int half;
        logic i30, i27, i26, i25, i5, i3;
        logic [2:0] f3;
        mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        lo32 = 64'h0000_0000_FFFF_FFFF;
        half = xl / 2;
        a = a_in & mask; b = b_in & mask; x = c_in & mask;
        sa = (xl == 64) ? a : {{32{a[31]}}, a[31:0]};
        sb = (xl == 64) ? b : {{32{b[31]}}, b[31:0]};
        {i30, i27, i26, i25, f3} = c[8:2];
        i5 = (xl == 64) ? c[1] : 1'b1;
        i3 = (xl == 64) ? c[0] : 1'b0;
        r = 0;
        if (i26) begin
            if (f3 == 1) r = (a & b) | (x & ~b);
            else if (f3 == 5) r = (b != 0) ? a : x;
        end else if (!i3) begin
            if (!i27) begin
                if (i30 && f3 == 7) r = a & ~b;
                else if (i30 && f3 == 6) r = a | ~b;
                else if (i30 && f3 == 4) r = ~(a ^ b);
            end else if (i25) begin
                if (f3 == 4) r = ($signed(sa) < $signed(sb)) ? a : b;
                else if (f3 == 5) r = ($signed(sa) > $signed(sb)) ? a : b;
                else if (f3 == 6) r = (a < b) ? a : b;
                else if (f3 == 7) r = (a > b) ? a : b;
            end else begin
                if (f3 == 4 && !i30) r = ((b & (mask >> half)) << half) | (a & (mask >> half));
                else if (f3 == 4 && i30) r = ((b >> half) << half) | (a >> half);
                else if (f3 == 7) r = ((b & 64'hFF) << 8) | (a & 64'hFF);
            end
        end else if (f3 == 0) begin
            if (!i5) r = (a + b) & lo32;
            else if (i25) r = (i30 ? (a - b) : (a + b)) & lo32;
            else if (i27) r = i30 ? (a - (b & lo32)) : (a + (b & lo32));
        end
        return r & mask;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit rand_ready();
        return $urandom_range(0, 7) < rdy_eighths;
    endfunction

    function automatic logic [63:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 64'h0;
            1: return 64'hFFFF_FFFF_FFFF_FFFF;
            2: return 64'h0000_0000_FFFF_FFFF;
            3: return {32'h8000_0000, $urandom};
            4: return {$urandom, 32'h8000_0000};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    function automatic logic [8:0] rand_ctl();
        logic [8:0] t[17];
        t[0]  = mk(3'd1, 0, 0, 1, 0, 1, 0);  t[1]  = mk(3'd5, 0, 0, 1, 0, 1, 0);
        t[2]  = mk(3'd7, 1, 0, 0, 0, 1, 0);  t[3]  = mk(3'd6, 1, 0, 0, 0, 1, 0);
        t[4]  = mk(3'd4, 1, 0, 0, 0, 1, 0);  t[5]  = mk(3'd4, 0, 1, 0, 1, 1, 0);
        t[6]  = mk(3'd5, 0, 1, 0, 1, 1, 0);  t[7]  = mk(3'd6, 0, 1, 0, 1, 1, 0);
        t[8]  = mk(3'd7, 0, 1, 0, 1, 1, 0);  t[9]  = mk(3'd4, 0, 1, 0, 0, 1, 0);
        t[10] = mk(3'd4, 1, 1, 0, 0, 1, 0);  t[11] = mk(3'd7, 0, 1, 0, 0, 1, 0);
        t[12] = mk(3'd0, 0, 0, 0, 0, 0, 1);  t[13] = mk(3'd0, 0, 0, 0, 1, 1, 1);
        t[14] = mk(3'd0, 1, 0, 0, 1, 1, 1);  t[15] = mk(3'd0, 0, 1, 0, 0, 1, 1);
        t[16] = mk(3'd0, 1, 1, 0, 0, 1, 1);
        if ($urandom_range(0, 9) < 3) return 9'($urandom);
        return t[$urandom_range(0, 16)];
    endfunction

    task automatic monitor_one(input int id, input logic v, input logic [63:0] rd);
        logic [63:0] exp;
        if (prev_stall[id]) begin
            chk(id == 0 ? "stall_valid32" : "stall_valid64", {63'b0, v}, 64'd1);
            chk(id == 0 ? "stall_rd32" : "stall_rd64", rd, prev_rd[id]);
        end
        if (v && dout_ready) begin
            if ((id == 0 && q32.size() == 0) || (id == 1 && q64.size() == 0)) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_result%0d actual=%h required=no output", id, rd);
            end else begin
                exp = (id == 0) ? q32.pop_front() : q64.pop_front();
                chk(id == 0 ? "result32" : "result64", rd, exp);
            end
        end
        prev_stall[id] = v && !dout_ready;
        prev_rd[id]    = rd;
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            prev_stall[0] = 1'b0;
            prev_stall[1] = 1'b0;
        end else begin
            monitor_one(0, dout_valid32, {32'b0, dout_rd32});
            monitor_one(1, dout_valid64, dout_rd64);
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic issue(input logic [63:0] a, b, c, input logic [8:0] op,
                         input logic [63:0] e32, e64);
        int tries;
        bit done;
        tries = 0;
        done = 0;
        din_valid = 1'b1;
        rs1 = a; rs2 = b; rs3 = c; ctl = op;
        while (!done) begin
            dout_ready = rand_ready();
            #1;
            if (din_ready32) q32.push_back(e32);
            if (din_ready64) q64.push_back(e64);
            done = din_ready32 || din_ready64;
            @(posedge clock);
            #1;
            if (!done) begin
                tries++;
                if (tries > 50) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL accept_timeout actual=din_ready low required=accept within 50 cycles");
                    done = 1;
                end
            end
        end
        din_valid = 1'b0;
    endtask

    task automatic idle();
        din_valid = 1'b0;
        rs1 = rand_operand(); rs2 = rand_operand(); rs3 = rand_operand(); ctl = 9'($urandom);
        dout_ready = rand_ready();
        @(posedge clock);
        #1;
    endtask

    task automatic d32(input logic [63:0] a, b, c, input logic [8:0] op, input logic [63:0] e32);
        issue(a, b, c, op, e32, model(64, a, b, c, op));
    endtask

    task automatic d64(input logic [63:0] a, b, c, input logic [8:0] op, input logic [63:0] e64);
        issue(a, b, c, op, model(32, a, b, c, op), e64);
    endtask

    task automatic do_reset();
        din_valid = 1'b0;
        reset = 1'b0;
        dout_ready = rand_ready();
        q32.delete();
        q64.delete();
        @(posedge clock);
        #1;
        chk("reset_valid32", {63'b0, dout_valid32}, 64'd0);
        chk("reset_valid64", {63'b0, dout_valid64}, 64'd0);
        chk("reset_rd64", dout_rd64, 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [63:0] a, b, c;
        logic [8:0] op;
        int waited;

        repeat (2) @(posedge clock);
        #1;
        chk("por_valid32", {63'b0, dout_valid32}, 64'd0);
        chk("por_rd32", {32'b0, dout_rd32}, 64'd0);
        chk("por_valid64", {63'b0, dout_valid64}, 64'd0);
        chk("por_ready64", {63'b0, din_ready64}, 64'd1);
        reset = 1'b1;

        rdy_eighths = 8;
        d32(64'hFFFF00FF, 64'h0F0F0F0F, 0, mk(3'd7, 1, 0, 0, 0, 1, 0), 64'hF0F000F0);
        chk("andn_latency_valid", {63'b0, dout_valid32}, 64'd1);
        chk("andn_latency_rd", {32'b0, dout_rd32}, 64'hF0F000F0);
        d32(64'hFFFFFFFF, 64'h1, 0, mk(3'd4, 0, 1, 0, 1, 1, 0), 64'hFFFFFFFF);
        d32(64'hFFFFFFFF, 64'h1, 0, mk(3'd6, 0, 1, 0, 1, 1, 0), 64'h00000001);
        d32(64'hFFFFFFFF, 64'h1, 0, mk(3'd7, 0, 1, 0, 1, 1, 0), 64'hFFFFFFFF);
        d32(64'h12345678, 64'h9ABCDEF0, 0, mk(3'd4, 0, 1, 0, 0, 1, 0), 64'hDEF05678);
        d32(64'h12345678, 64'h9ABCDEF0, 0, mk(3'd4, 1, 1, 0, 0, 1, 0), 64'h9ABC1234);
        d32(64'h12345678, 64'h9ABCDEF0, 0, mk(3'd7, 0, 1, 0, 0, 1, 0), 64'h0000F078);
        d32(64'd5, 64'd0, 64'd7, mk(3'd5, 0, 0, 1, 0, 1, 0), 64'd7);
        d32(64'd5, 64'd1, 64'd7, mk(3'd5, 0, 0, 1, 0, 1, 0), 64'd5);
        d32(64'hAAAAAAAA, 64'hFFFF0000, 64'h55555555, mk(3'd1, 0, 0, 1, 0, 1, 0), 64'hAAAA5555);
        d32(64'h1234, 64'h5678, 64'h9, mk(3'd0, 0, 0, 0, 0, 1, 0), 64'd0);
        d64(64'hFFFFFFFF, 64'h1, 0, mk(3'd0, 0, 0, 0, 1, 1, 1), 64'h0);
        d64(64'h0, 64'hFFFFFFFF00000001, 0, mk(3'd0, 1, 1, 0, 0, 1, 1), 64'hFFFFFFFFFFFFFFFF);
        d64(64'hFFFFFFFF, 64'h2, 0, mk(3'd0, 0, 0, 0, 0, 0, 1), 64'h1);
        d64(64'h1, 64'h2, 0, mk(3'd0, 1, 0, 0, 1, 1, 1), 64'hFFFFFFFF);

        rdy_eighths = 7;
        for (int i = 0; i < 1000; i++) begin
            if (i == 500) do_reset();
            while ($urandom_range(0, 3) == 0) idle();
            a = rand_operand(); b = rand_operand(); c = rand_operand();
            op = rand_ctl();
            issue(a, b, c, op, model(32, a, b, c, op), model(64, a, b, c, op));
        end

        din_valid = 1'b0;
        rdy_eighths = 8;
        dout_ready = 1'b1;
        waited = 0;
        while ((q32.size() != 0 || q64.size() != 0) && waited < 20) begin
            @(posedge clock);
            #1;
            waited++;
        end
        chk("drain_pending32", 64'(q32.size()), 64'd0);
        chk("drain_pending64", 64'(q64.size()), 64'd0);
        @(posedge clock);
        #1;
        chk("idle_valid32", {63'b0, dout_valid32}, 64'd0);
        chk("idle_valid64", {63'b0, dout_valid64}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rvb_simple_core.md
Name: rvb_simple_core

Overview:
Single-cycle-compute, one-stage-registered execution unit for the "simple" RISC-V bitmanip instructions: logic-with-negate, min/max, pack, cmix/cmov, and the 64-bit unsigned-word add/sub ops. It sits beside the core ALU and uses a valid/ready stream in and out. Operands and a subset of instruction bits are supplied; the unit decodes them itself.

Parameters:
XLEN, 32, datapath width; legal values are 32 or 64. The W-ops and the insn3/insn5 inputs are used only when XLEN=64.

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
din_valid  in  1  input operation valid
din_ready  out  1  unit accepts input this cycle
din_rs1  in  XLEN  operand rs1
din_rs2  in  XLEN  operand rs2; for the immediate form it carries the sign-extended immediate
din_rs3  in  XLEN  operand rs3 (ternary ops)
din_insn3, din_insn5  in  1 each  instruction bits 3 and 5; ignored when XLEN=32
din_insn12, din_insn13, din_insn14  in  1 each  funct3 (f3 = {insn14,insn13,insn12})
din_insn25, din_insn26, din_insn27, din_insn30  in  1 each  funct7 bits
dout_valid  out  1  result valid
dout_ready  in  1  consumer accepts result
dout_rd  out  XLEN  result

Behaviour:
- Reset (reset==0 at a rising edge): dout_valid<=0, dout_rd<=0. din_ready is combinational and is 1 immediately after reset.
- din_ready = !dout_valid || dout_ready, giving full throughput of one op per cycle.
- Accept: when din_valid && din_ready, the result is computed combinationally, registered into dout_rd, and dout_valid<=1. Latency is exactly 1 cycle.
- No accept but dout_ready is high: dout_valid<=0.
- Otherwise dout_valid and dout_rd hold; dout_rd stays stable while dout_valid && !dout_ready.
- Simultaneous input accept and output drain in the same cycle: the new result replaces the old, and dout_valid stays 1.
- Inputs are sampled only on accept.
- Decode: insn26 has priority. When XLEN=32, treat insn3=0 and insn5=1.
  - insn26=1, f3=001, cmix: (rs1&rs2)|(rs3&~rs2).
  - insn26=1, f3=101, cmov: rs2!=0 ? rs1 : rs3.
  - insn3=0, insn27=0, insn30=1, f3=111, andn: rs1&~rs2.
  - insn3=0, insn27=0, insn30=1, f3=110, orn: rs1|~rs2.
  - insn3=0, insn27=0, insn30=1, f3=100, xnor: ~(rs1^rs2).
  - insn3=0, insn27=1, insn25=1, f3=100/101/110/111: min (signed), max (signed), minu, maxu.
  - insn3=0, insn27=1, insn25=0, f3=100, insn30=0, pack: {rs2[XLEN/2-1:0], rs1[XLEN/2-1:0]}.
  - insn3=0, insn27=1, insn25=0, f3=100, insn30=1, packu: {rs2[XLEN-1:XLEN/2], rs1[XLEN-1:XLEN/2]}.
  - insn3=0, insn27=1, insn25=0, f3=111, packh: zero-extended {rs2[7:0], rs1[7:0]}.
  - XLEN=64, insn3=1, f3=000, insn5=0, addiwu: zext32(rs1[31:0]+rs2[31:0]).
  - XLEN=64, insn3=1, f3=000, insn5=1, insn25=1: addwu (insn30=0) zext32(rs1[31:0]+rs2[31:0]); subwu (insn30=1) zext32(rs1[31:0]-rs2[31:0]).
  - XLEN=64, insn3=1, f3=000, insn5=1, insn25=0, insn27=1: addu.w (insn30=0) rs1+zext32(rs2[31:0]); subu.w (insn30=1) rs1-zext32(rs2[31:0]).
  - Any other combination: rd=0. It is still accepted and completes with normal handshake.
- Arithmetic wraps modulo 2^XLEN (2^32 for the zext32 forms); there are no flags or exceptions.
- Reset asserted mid-operation drops any pending result; the next accepted op after reset is handled normally.

Test Plan:
- XLEN=32, andn (insn30=1, f3=111), rs1=0xFFFF00FF, rs2=0x0F0F0F0F -> dout_rd=0xF0F000F0 one cycle after accept, dout_valid=1.
- min vs minu, rs1=0xFFFFFFFF, rs2=0x00000001: min -> 0xFFFFFFFF; minu -> 0x00000001; maxu -> 0xFFFFFFFF.
- pack: rs1=0x12345678, rs2=0x9ABCDEF0 -> 0xDEF05678; packu -> 0x9ABC1234; packh -> 0x0000F078.
- cmov: rs1=5, rs2=0, rs3=7 -> 7; with rs2=1 -> 5. cmix: rs1=0xAAAAAAAA, rs2=0xFFFF0000, rs3=0x55555555 -> 0xAAAA5555.
- XLEN=64, addwu: rs1=0xFFFFFFFF, rs2=1 -> 0. subu.w: rs1=0, rs2=0xFFFFFFFF00000001 -> 0xFFFFFFFFFFFFFFFF.
- Backpressure: 1000 random ops with random din_valid (75%) and dout_ready (87.5%) -> results arrive in order, none lost or duplicated, dout_rd stable while stalled, dout_valid=0 during reset.
